// File: rtl/serial_rx_4_beh.sv
// serial_rx_4_beh: LSB-first serial frame receiver (start, 4 data,
// optional even parity, stop) with a valid/ready holding register.
// Ports:
//   clk        - system clock, posedge
//   clear      - synchronous active-low reset
//   serial_in  - serial line, idle high
//   bit_en     - sample strobe for serial_in
//   parity_en  - frame carries parity (latched at start bit)
//   rx_ready   - consumer accepts held word
//   a_par      - received data word
//   rx_valid   - held word is unconsumed
//   parity_err - held word failed parity
//   frame_err  - held word had stop bit = 0
//   overrun    - sticky: a completed frame was dropped
//   busy       - frame in progress
module serial_rx_4_beh (
    input  logic       clk,
    input  logic       clear,
    input  logic       serial_in,
    input  logic       bit_en,
    input  logic       parity_en,
    input  logic       rx_ready,
    output logic [3:0] a_par,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t     state_q;
    logic [1:0] cnt_q;
    logic [3:0] sr_q;
    logic       par_en_q;
    logic       p_err_q;
    logic [3:0] a_par_q;
    logic       rx_valid_q;
    logic       parity_err_q;
    logic       frame_err_q;
    logic       overrun_q;

    logic consume;
    logic room;

    // Holding register is free if empty or being emptied this edge.
    assign consume = rx_valid_q & rx_ready;
    assign room    = ~rx_valid_q | rx_ready;

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            sr_q         <= 4'd0;
            par_en_q     <= 1'b0;
            p_err_q      <= 1'b0;
            a_par_q      <= 4'd0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (consume) begin
                rx_valid_q <= 1'b0;
            end
            if (bit_en) begin
                unique case (state_q)
                    IDLE: begin
                        if (!serial_in) begin
                            state_q  <= DATA;
                            cnt_q    <= 2'd0;
                            par_en_q <= parity_en;
                            p_err_q  <= 1'b0;
                        end
                    end
                    DATA: begin
                        sr_q  <= {serial_in, sr_q[3:1]};
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= par_en_q ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        p_err_q <= (serial_in != ^sr_q);
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (room) begin
                            a_par_q      <= sr_q;
                            parity_err_q <= par_en_q & p_err_q;
                            frame_err_q  <= ~serial_in;
                            rx_valid_q   <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign a_par      = a_par_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx_4_beh.sv
// tb_serial_rx_4_beh: table-driven frame vectors plus directed
// sequences for reset, overrun and same-edge consume/complete.
module tb_serial_rx_4_beh;

    logic       clk;
    logic       clear;
    logic       serial_in;
    logic       bit_en;
    logic       parity_en;
    logic       rx_ready;
    logic [3:0] a_par;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int nvec;
    int nmiss;

    serial_rx_4_beh dut (
        .clk       (clk),
        .clear     (clear),
        .serial_in (serial_in),
        .bit_en    (bit_en),
        .parity_en (parity_en),
        .rx_ready  (rx_ready),
        .a_par     (a_par),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic       pen;
        logic       p;
        logic       stop;
        int         gap;
        logic [3:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vec[7];

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one bit with one strobe, then gap idle cycles.
    task automatic send_bit(input logic b, input int gap);
        serial_in = b;
        bit_en    = 1'b1;
        tick();
        bit_en = 1'b0;
        repeat (gap) tick();
    endtask

    function automatic logic [7:0] mk(input logic [3:0] d, input logic pen,
                                      input logic p, input logic stop);
        logic [7:0] f;
        f      = 8'hFF;
        f[0]   = 1'b0;
        f[4:1] = d;
        if (pen) begin
            f[5] = p;
            f[6] = stop;
        end else begin
            f[5] = stop;
        end
        return f;
    endfunction

    // Sends the whole frame; flips parity_en after the start bit.
    task automatic send_frame(input logic [3:0] d, input logic pen,
                              input logic p, input logic stop,
                              input int gap);
        logic [7:0] f;
        int n;
        f = mk(d, pen, p, stop);
        n = pen ? 7 : 6;
        parity_en = pen;
        for (int i = 0; i < n; i++) begin
            send_bit(f[i], (i == n - 1) ? 0 : gap);
            if (i == 0) parity_en = ~pen;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " a_par"}, a_par, 4'h0);
        check({tag, " valid"}, {3'b0, rx_valid}, 4'h0);
        check({tag, " perr"}, {3'b0, parity_err}, 4'h0);
        check({tag, " ferr"}, {3'b0, frame_err}, 4'h0);
        check({tag, " ovr"}, {3'b0, overrun}, 4'h0);
        check({tag, " busy"}, {3'b0, busy}, 4'h0);
    endtask

    initial begin
        nvec  = 0;
        nmiss = 0;

        vec[0] = '{4'b1011, 1'b0, 1'b0, 1'b1, 0, 4'b1011, 1'b0, 1'b0};
        vec[1] = '{4'b1011, 1'b1, 1'b1, 1'b1, 2, 4'b1011, 1'b0, 1'b0};
        vec[2] = '{4'b1011, 1'b1, 1'b0, 1'b1, 2, 4'b1011, 1'b1, 1'b0};
        vec[3] = '{4'b0110, 1'b0, 1'b0, 1'b0, 1, 4'b0110, 1'b0, 1'b1};
        vec[4] = '{4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0000, 1'b0, 1'b0};
        vec[5] = '{4'b1111, 1'b1, 1'b1, 1'b1, 1, 4'b1111, 1'b1, 1'b0};
        vec[6] = '{4'b0101, 1'b1, 1'b0, 1'b0, 0, 4'b0101, 1'b0, 1'b1};

        clear     = 1'b0;
        serial_in = 1'b1;
        bit_en    = 1'b0;
        parity_en = 1'b0;
        rx_ready  = 1'b0;
        tick();
        tick();
        check_zero("reset");
        clear = 1'b1;
        tick();

        // Abort a frame mid-way with a 2-cycle reset.
        parity_en = 1'b0;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("midframe busy", {3'b0, busy}, 4'h1);
        clear = 1'b0;
        tick();
        tick();
        check_zero("midreset");
        clear = 1'b1;
        serial_in = 1'b1;
        tick();

        rx_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1, 0);
            send_bit(1'b1, 1);
            send_frame(vec[i].d, vec[i].pen, vec[i].p, vec[i].stop,
                       vec[i].gap);
            check($sformatf("v%0d valid", i), {3'b0, rx_valid}, 4'h1);
            check($sformatf("v%0d data", i), a_par, vec[i].exp_d);
            check($sformatf("v%0d perr", i), {3'b0, parity_err},
                  {3'b0, vec[i].exp_pe});
            check($sformatf("v%0d ferr", i), {3'b0, frame_err},
                  {3'b0, vec[i].exp_fe});
            check($sformatf("v%0d busy", i), {3'b0, busy}, 4'h0);
            serial_in = 1'b1;
            tick();
            check($sformatf("v%0d consumed", i), {3'b0, rx_valid}, 4'h0);
        end

        // Overrun: two frames with consumer stalled.
        rx_ready = 1'b0;
        send_frame(4'b0001, 1'b0, 1'b0, 1'b1, 1);
        send_bit(1'b1, 0);
        send_frame(4'b1110, 1'b0, 1'b0, 1'b1, 1);
        check("ovr data", a_par, 4'b0001);
        check("ovr valid", {3'b0, rx_valid}, 4'h1);
        check("ovr flag", {3'b0, overrun}, 4'h1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("ovr drained", {3'b0, rx_valid}, 4'h0);
        check("ovr sticky", {3'b0, overrun}, 4'h1);
        tick();
        tick();
        check("ovr sticky2", {3'b0, overrun}, 4'h1);
        clear = 1'b0;
        tick();
        clear = 1'b1;
        check("ovr cleared", {3'b0, overrun}, 4'h0);

        // Back-to-back frames, bit_en continuous; consume on the
        // second frame's stop edge.
        begin
            logic [7:0] f;
            parity_en = 1'b0;
            f = mk(4'b0011, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 6; i++) send_bit(f[i], 0);
            f = mk(4'b1100, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 5; i++) send_bit(f[i], 0);
            check("sim held", a_par, 4'b0011);
            rx_ready = 1'b1;
            send_bit(f[5], 0);
            rx_ready = 1'b0;
            check("sim valid", {3'b0, rx_valid}, 4'h1);
            check("sim data", a_par, 4'b1100);
            check("sim ovr", {3'b0, overrun}, 4'h0);
            tick();
            check("sim hold", a_par, 4'b1100);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            check("sim drained", {3'b0, rx_valid}, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
